// File: rtl/retrieve_pkg.sv
// Shared definitions for the ring-buffer receive read side.
//   state_e : read-slot FSM encoding (IDLE plus the three slot phases)
//   size_ok : true when the buffer depth is an exact power of two of the pointer width
package retrieve_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_ADVANCE = 2'd3
  } state_e;

  // Pointers rely on natural binary rollover, so depth must be exactly 2**width.
  function automatic bit size_ok(input int unsigned counter_size, input int unsigned buffer_size);
    return buffer_size == (32'd1 << counter_size);
  endfunction

endpackage

// File: rtl/ring_ptr_counter.sv
// Write/read pointer and fill-count bookkeeping for the receive ring buffer.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   write             : writer stored a bit this cycle (dropped when full)
//   advance           : reader consumed the head entry this cycle
//   ovfclr            : synchronous clear of the sticky overflow flag
//   wrptr, rdptr      : ring pointers, wrap modulo buffer_size
//   count, count_next : fill level (0..buffer_size) and its value after this edge
//   full, empty       : decoded from count only
//   overflow          : sticky, set when a write is dropped while full
module ring_ptr_counter #(
  parameter int unsigned counter_size = 2,
  parameter int unsigned buffer_size  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write,
  input  logic                    advance,
  input  logic                    ovfclr,
  output logic [counter_size-1:0] wrptr,
  output logic [counter_size-1:0] rdptr,
  output logic [counter_size:0]   count,
  output logic [counter_size:0]   count_next,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  logic                    accept;
  logic                    drop;
  logic [counter_size-1:0] wrptr_next;
  logic [counter_size-1:0] rdptr_next;
  logic                    overflow_next;

  assign full   = (count == (counter_size + 1)'(buffer_size));
  assign empty  = (count == '0);
  // full is the pre-edge value, so a write racing an advance while full is still dropped
  assign accept = write & ~full;
  assign drop   = write & full;

  always_comb begin
    wrptr_next    = wrptr;
    rdptr_next    = rdptr;
    count_next    = count;
    overflow_next = overflow;
    if (accept) wrptr_next = wrptr + 1'b1;
    if (advance) rdptr_next = rdptr + 1'b1;
    case ({accept, advance})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    // A drop in the same cycle as a clear wins so the event is never lost.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovfclr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrptr    <= '0;
      rdptr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wrptr    <= wrptr_next;
      rdptr    <= rdptr_next;
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: rtl/retrieve_sequencer.sv
// Read-side controller for the ring-buffer receive path. Serializes one stored bit per
// three-cycle slot (SETUP, STROBE, ADVANCE) while downstream is ready.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   instrobe     : writer stored one bit at wradrs this cycle
//   rxready      : downstream can accept a bit (looked at in IDLE and ADVANCE only)
//   ovfclr       : synchronous clear of overflow
//   wradrs       : write pointer to the buffer writer
//   ramadrs      : {count, rdptr} to the bit-select retriever
//   outstrobe    : qualifies rxda at the retriever, one cycle per bit
//   full, empty  : fill status decoded from count
//   overflow     : sticky dropped-write flag
module retrieve_sequencer
  import retrieve_pkg::*;
#(
  parameter int unsigned counter_size = 2,
  parameter int unsigned buffer_size  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    instrobe,
  input  logic                    rxready,
  input  logic                    ovfclr,
  output logic [counter_size-1:0] wradrs,
  output logic [2*counter_size:0] ramadrs,
  output logic                    outstrobe,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  if (!size_ok(counter_size, buffer_size)) begin : gen_size_check
    $error("retrieve_sequencer: buffer_size must equal 2**counter_size");
  end

  state_e                  state;
  state_e                  state_next;
  logic                    advance;
  logic [counter_size-1:0] rdptr;
  logic [counter_size:0]   count;
  logic [counter_size:0]   count_next;

  assign advance = (state == ST_ADVANCE);

  ring_ptr_counter #(
    .counter_size (counter_size),
    .buffer_size  (buffer_size)
  ) u_ring_ptr_counter (
    .clock      (clock),
    .reset      (reset),
    .write      (instrobe),
    .advance    (advance),
    .ovfclr     (ovfclr),
    .wrptr      (wradrs),
    .rdptr      (rdptr),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (!empty && rxready) state_next = ST_SETUP;
      // SETUP only holds ramadrs for a cycle so the retriever output settles.
      ST_SETUP:   state_next = ST_STROBE;
      ST_STROBE:  state_next = ST_ADVANCE;
      ST_ADVANCE: state_next = ((count_next != '0) && rxready) ? ST_SETUP : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decoded from the state register, so reset removes the strobe immediately.
  assign outstrobe = (state == ST_STROBE);
  assign ramadrs   = {count, rdptr};

endmodule

// File: tb/tb_retrieve_sequencer.sv
// Bench for retrieve_sequencer with a shift-buffer writer and bit-select retriever around it.
// The reference model is a bit queue plus a slot-phase counter advanced once per clock.
module tb_retrieve_sequencer;

  logic       clock;
  logic       reset;
  logic       instrobe;
  logic       rxready;
  logic       ovfclr;
  logic [1:0] wradrs;
  logic [4:0] ramadrs;
  logic       outstrobe;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       rxda;
  logic       din;
  logic [3:0] buffer;

  int tests;
  int fails;

  // Reference model: queued bits, pointer values, sticky flag, slot phase (0 idle,
  // 1 first slot cycle, 2 strobe cycle, 3 last slot cycle).
  bit m_q[$];
  int m_wp;
  int m_rd;
  bit m_ovf;
  int m_slot;

  retrieve_sequencer #(
    .counter_size (2),
    .buffer_size  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .instrobe  (instrobe),
    .rxready   (rxready),
    .ovfclr    (ovfclr),
    .wradrs    (wradrs),
    .ramadrs   (ramadrs),
    .outstrobe (outstrobe),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  assign rxda = buffer[ramadrs[1:0]] & outstrobe;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_clear();
    m_q.delete();
    m_wp = 0;
    m_rd = 0;
    m_ovf = 1'b0;
    m_slot = 0;
  endtask

  task automatic model_step();
    int  pre_size;
    bit  acc;
    bit  drop;
    pre_size = m_q.size();
    acc  = instrobe && (pre_size < 4);
    drop = instrobe && (pre_size == 4);
    if (m_slot == 3) begin
      void'(m_q.pop_front());
      m_rd = (m_rd + 1) % 4;
    end
    if (acc) begin
      m_q.push_back(din);
      m_wp = (m_wp + 1) % 4;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovfclr) m_ovf = 1'b0;
    case (m_slot)
      0:       m_slot = (pre_size > 0 && rxready) ? 1 : 0;
      1:       m_slot = 2;
      2:       m_slot = 3;
      default: m_slot = (m_q.size() > 0 && rxready) ? 1 : 0;
    endcase
  endtask

  // One clock: the writer stores into the buffer, the model advances, return 1ns after the edge.
  task automatic tick();
    logic       pre_full;
    logic [1:0] pre_wr;
    pre_full = full;
    pre_wr   = wradrs;
    @(posedge clock);
    if (instrobe && !pre_full) buffer[pre_wr] = din;
    model_step();
    #1;
  endtask

  // Called 1ns after an edge; reset pulse stays clear of the next edge.
  task automatic apply_reset();
    instrobe = 1'b0;
    ovfclr   = 1'b0;
    rxready  = 1'b0;
    reset    = 1'b0;
    #2;
    model_clear();
    reset = 1'b1;
    #1;
  endtask

  task automatic write_bit(input logic b);
    instrobe = 1'b1;
    din      = b;
    tick();
    instrobe = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) write_bit(1'b1);
    rxready = 1'b1;
    for (int i = 0; i < 10 && m_slot != 2; i++) tick();
    tests++;
    if (outstrobe !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL reset_prestate: outstrobe=%b overflow=%b, required 1 1", outstrobe, overflow);
    end
    #1;
    reset = 1'b0;
    #2;
    tests++;
    if (outstrobe !== 1'b0) begin
      fails++;
      $display("FAIL reset_outstrobe: got %b required 0", outstrobe);
    end
    tests++;
    if (ramadrs !== 5'b00000) begin
      fails++;
      $display("FAIL reset_ramadrs: got %b required 00000", ramadrs);
    end
    tests++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: empty=%b full=%b required 1 0", empty, full);
    end
    tests++;
    if (overflow !== 1'b0 || wradrs !== 2'd0) begin
      fails++;
      $display("FAIL reset_ovf_wr: overflow=%b wradrs=%0d required 0 0", overflow, wradrs);
    end
    model_clear();
    reset = 1'b1;
    tick();
    tests++;
    if (outstrobe !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_after: outstrobe=%b empty=%b required 0 1", outstrobe, empty);
    end
  endtask

  task automatic test_single_bit();
    apply_reset();
    rxready = 1'b1;
    write_bit(1'b1);
    tick();
    tests++;
    if (outstrobe !== 1'b0) begin
      fails++;
      $display("FAIL single_setup: outstrobe=%b required 0", outstrobe);
    end
    tick();
    tests++;
    if (outstrobe !== 1'b1 || rxda !== 1'b1) begin
      fails++;
      $display("FAIL single_strobe: outstrobe=%b rxda=%b required 1 1", outstrobe, rxda);
    end
    tick();
    tests++;
    if (outstrobe !== 1'b0) begin
      fails++;
      $display("FAIL single_advance: outstrobe=%b required 0", outstrobe);
    end
    tick();
    tests++;
    if (ramadrs !== 5'b00001 || empty !== 1'b1) begin
      fails++;
      $display("FAIL single_done: ramadrs=%b empty=%b required 00001 1", ramadrs, empty);
    end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      write_bit(1'($urandom_range(1)));
      if (i == 2) begin
        tests++;
        if (full !== 1'b0) begin
          fails++;
          $display("FAIL fill_3: full=%b required 0", full);
        end
      end
      if (i == 3) begin
        tests++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL fill_4: full=%b overflow=%b required 1 0", full, overflow);
        end
      end
      if (i == 4) begin
        tests++;
        if (overflow !== 1'b1 || wradrs !== 2'd0 || full !== 1'b1) begin
          fails++;
          $display("FAIL fill_5: overflow=%b wradrs=%0d full=%b required 1 0 1",
                   overflow, wradrs, full);
        end
      end
    end
    ovfclr = 1'b1;
    tick();
    ovfclr = 1'b0;
    tests++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      fails++;
      $display("FAIL ovf_clear: overflow=%b full=%b required 0 1", overflow, full);
    end
    // Drop and clear together: the drop must win.
    ovfclr = 1'b1;
    write_bit(1'b0);
    ovfclr = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_priority: overflow=%b required 1", overflow);
    end
  endtask

  task automatic test_drain_order();
    bit pattern[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int at[4];
    bit got[4];
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) write_bit(pattern[i]);
    rxready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (outstrobe === 1'b1) begin
        if (n < 4) begin
          at[n]  = c;
          got[n] = rxda;
        end
        n++;
      end
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL drain_count: got %0d strobes required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got[i] !== pattern[i]) begin
          fails++;
          $display("FAIL drain_bit%0d: rxda=%b required %b", i, got[i], pattern[i]);
        end
      end
      tests++;
      if (at[0] != 1 || at[1] - at[0] != 3 || at[2] - at[1] != 3 || at[3] - at[2] != 3) begin
        fails++;
        $display("FAIL drain_spacing: strobes at %0d %0d %0d %0d required 1 4 7 10",
                 at[0], at[1], at[2], at[3]);
      end
    end
    tests++;
    if (ramadrs !== 5'b00000 || outstrobe !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL drain_end: ramadrs=%b outstrobe=%b empty=%b required 00000 0 1",
               ramadrs, outstrobe, empty);
    end
  endtask

  task automatic test_concurrent();
    apply_reset();
    write_bit(1'b0);
    write_bit(1'b1);
    rxready = 1'b1;
    for (int i = 0; i < 10 && m_slot != 3; i++) tick();
    tests++;
    if (m_slot != 3 || outstrobe !== 1'b0) begin
      fails++;
      $display("FAIL conc_reach: phase=%0d outstrobe=%b required 3 0", m_slot, outstrobe);
    end
    write_bit(1'b1);
    tests++;
    if (ramadrs !== 5'b01001 || wradrs !== 2'd3) begin
      fails++;
      $display("FAIL conc_ptrs: ramadrs=%b wradrs=%0d required 01001 3", ramadrs, wradrs);
    end
  endtask

  task automatic test_backpressure();
    int extra;
    apply_reset();
    write_bit(1'b1);
    write_bit(1'b0);
    rxready = 1'b1;
    tick();
    rxready = 1'b0;
    tick();
    tests++;
    if (outstrobe !== 1'b1 || rxda !== 1'b1) begin
      fails++;
      $display("FAIL bp_inflight: outstrobe=%b rxda=%b required 1 1", outstrobe, rxda);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (outstrobe === 1'b1) extra++;
    end
    tests++;
    if (extra != 0 || ramadrs !== 5'b00101) begin
      fails++;
      $display("FAIL bp_hold: strobes=%0d ramadrs=%b required 0 00101", extra, ramadrs);
    end
    rxready = 1'b1;
    tick();
    tick();
    tests++;
    if (outstrobe !== 1'b1 || rxda !== 1'b0) begin
      fails++;
      $display("FAIL bp_resume: outstrobe=%b rxda=%b required 1 0", outstrobe, rxda);
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_ram;
    logic       exp_rxda;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      // Alternate write-heavy and read-heavy phases to reach full and empty often.
      if ((c / 75) % 2 == 0) begin
        instrobe = ($urandom_range(3) != 0);
        rxready  = ($urandom_range(3) == 0);
      end else begin
        instrobe = ($urandom_range(3) == 0);
        rxready  = ($urandom_range(3) != 0);
      end
      din    = 1'($urandom_range(1));
      ovfclr = ($urandom_range(7) == 0);
      tick();
      exp_ram  = {3'(m_q.size()), 2'(m_rd)};
      exp_rxda = (m_slot == 2) ? m_q[0] : 1'b0;
      tests++;
      if (outstrobe !== (m_slot == 2) || rxda !== exp_rxda) begin
        fails++;
        $display("FAIL rand_strobe c=%0d: outstrobe=%b rxda=%b required %b %b",
                 c, outstrobe, rxda, (m_slot == 2), exp_rxda);
      end
      tests++;
      if (ramadrs !== exp_ram || wradrs !== 2'(m_wp)) begin
        fails++;
        $display("FAIL rand_ptrs c=%0d: ramadrs=%b wradrs=%0d required %b %0d",
                 c, ramadrs, wradrs, exp_ram, m_wp);
      end
      tests++;
      if (full !== (m_q.size() == 4) || empty !== (m_q.size() == 0) || overflow !== m_ovf) begin
        fails++;
        $display("FAIL rand_status c=%0d: full=%b empty=%b overflow=%b required %b %b %b",
                 c, full, empty, overflow, (m_q.size() == 4), (m_q.size() == 0), m_ovf);
      end
    end
    instrobe = 1'b0;
    ovfclr   = 1'b0;
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    buffer   = '0;
    din      = 1'b0;
    instrobe = 1'b0;
    rxready  = 1'b0;
    ovfclr   = 1'b0;
    reset    = 1'b0;
    model_clear();
    #12;
    reset = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_single_bit();
    test_fill_overflow();
    test_drain_order();
    test_concurrent();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
